// File: rtl/sram_arbiter_if.sv
`timescale 1ns/1ps
// sram_arbiter_if
// Bundles the three buses around the SRAM arbiter:
//   amiga_*  : level-request port with a one-cycle ack pulse (16-bit word access)
//   spi_*    : toggle-request port (byte writes, word reads)
//   sram_*   : registered asynchronous-SRAM pins (active-low controls)
// Modports:
//   slave  : the arbiter (serves both requesters, drives the SRAM pins)
//   master : the environment (requesters plus SRAM device)
interface sram_arbiter_if;
  logic        amiga_req;
  logic        amiga_read;
  logic [19:0] amiga_address;
  logic        amiga_ub;
  logic        amiga_lb;
  logic [15:0] amiga_wdata;
  logic [15:0] amiga_rdata;
  logic        amiga_ack;

  logic        spi_req;
  logic        spi_ack;
  logic        spi_read_sram;
  logic [19:0] spi_address_sram;
  logic        spi_ub;
  logic [7:0]  spi_out_sram_in;
  logic [15:0] spi_in_sram_out;

  logic [19:0] sram_address;
  logic [15:0] sram_data_out;
  logic        sram_data_oe;
  logic [15:0] sram_data_in;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  modport slave (
    input  amiga_req, amiga_read, amiga_address, amiga_ub, amiga_lb, amiga_wdata,
    output amiga_rdata, amiga_ack,
    input  spi_req, spi_read_sram, spi_address_sram, spi_ub, spi_out_sram_in,
    output spi_ack, spi_in_sram_out,
    output sram_address, sram_data_out, sram_data_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
    input  sram_data_in
  );

  modport master (
    output amiga_req, amiga_read, amiga_address, amiga_ub, amiga_lb, amiga_wdata,
    input  amiga_rdata, amiga_ack,
    output spi_req, spi_read_sram, spi_address_sram, spi_ub, spi_out_sram_in,
    input  spi_ack, spi_in_sram_out,
    input  sram_address, sram_data_out, sram_data_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
    output sram_data_in
  );
endinterface

// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// sram_arbiter
// Shares one asynchronous 16-bit SRAM between an Amiga bus port and an SPI
// port. Each access runs IDLE -> SETUP -> STROBE (ACCESS_CYCLES) -> DONE, so
// the requester sees its ack ACCESS_CYCLES+2 cycles after the grant cycle.
// Simultaneous requests are served round-robin, Amiga first after reset.
// Ports:
//   clk200  : sole clock, every flop on its rising edge
//   reset_n : asynchronous active-low reset, aborts any access in flight
//   bus     : sram_arbiter_if.slave (Amiga port, SPI port, SRAM pins)
// All SRAM pins and both read-data ports are registered.
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 3
) (
  input  logic           clk200,
  input  logic           reset_n,
  sram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        armed;
  logic        last_spi;

  // Latched command of the access in flight
  logic        cmd_spi;
  logic        cmd_read;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_ub_n;
  logic        cmd_lb_n;
  logic        cmd_tag;

  // Command as it will be after this edge (port values on a grant, else held)
  logic        sel_spi;
  logic        sel_read;
  logic [19:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_ub_n;
  logic        sel_lb_n;
  logic        sel_tag;

  logic        amiga_pend, spi_pend, grant, grant_spi;

  // Registered outputs and their next values
  logic [19:0] addr_q, addr_nxt;
  logic [15:0] dout_q, dout_nxt;
  logic        doe_q, doe_nxt;
  logic        ce_n_q, ce_n_nxt;
  logic        oe_n_q, oe_n_nxt;
  logic        we_n_q, we_n_nxt;
  logic        ub_n_q, ub_n_nxt;
  logic        lb_n_q, lb_n_nxt;
  logic        amiga_ack_q, amiga_ack_nxt;
  logic        spi_ack_q, spi_ack_nxt;
  logic [15:0] amiga_rdata_q, amiga_rdata_nxt;
  logic [15:0] spi_rdata_q, spi_rdata_nxt;

  // Request qualification and round-robin choice
  assign amiga_pend = bus.amiga_req & armed;
  assign spi_pend   = bus.spi_req ^ spi_ack_q;
  assign grant      = (state == IDLE) && (amiga_pend || spi_pend);
  // last_spi=1 means SPI had the previous grant, so Amiga wins a tie
  assign grant_spi  = spi_pend && (!amiga_pend || !last_spi);

  always_comb begin
    sel_spi   = cmd_spi;
    sel_read  = cmd_read;
    sel_addr  = cmd_addr;
    sel_wdata = cmd_wdata;
    sel_ub_n  = cmd_ub_n;
    sel_lb_n  = cmd_lb_n;
    sel_tag   = cmd_tag;
    if (grant) begin
      sel_spi = grant_spi;
      if (grant_spi) begin
        sel_read  = bus.spi_read_sram;
        sel_addr  = bus.spi_address_sram;
        sel_wdata = {2{bus.spi_out_sram_in}};
        // Reads use both lanes; byte writes strobe only the chosen lane
        sel_ub_n  = bus.spi_read_sram ? 1'b0 : !bus.spi_ub;
        sel_lb_n  = bus.spi_read_sram ? 1'b0 : bus.spi_ub;
        sel_tag   = bus.spi_req;
      end else begin
        sel_read  = bus.amiga_read;
        sel_addr  = bus.amiga_address;
        sel_wdata = bus.amiga_wdata;
        // A write with neither lane enabled still runs and acks, strobing nothing
        sel_ub_n  = bus.amiga_read ? 1'b0 : !bus.amiga_ub;
        sel_lb_n  = bus.amiga_read ? 1'b0 : !bus.amiga_lb;
      end
    end
  end

  // Command registers hold whenever no grant happens; not part of reset
  // because nothing reads them before the first grant.
  always_ff @(posedge clk200) begin
    cmd_spi   <= sel_spi;
    cmd_read  <= sel_read;
    cmd_addr  <= sel_addr;
    cmd_wdata <= sel_wdata;
    cmd_ub_n  <= sel_ub_n;
    cmd_lb_n  <= sel_lb_n;
    cmd_tag   <= sel_tag;
  end

  // State register
  always_ff @(posedge clk200 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      armed    <= 1'b1;
      last_spi <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // A held request re-arms only after it has been seen low
      if (amiga_ack_q)
        armed <= 1'b0;
      else if (!bus.amiga_req)
        armed <= 1'b1;
      if (grant)
        last_spi <= grant_spi;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE:   if (grant) state_nxt = SETUP;
      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = CNT_LOAD;
      end
      STROBE: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      DONE:   state_nxt = IDLE;
    endcase
  end

  // Output logic: pins are registered, so decode from the state being entered
  always_comb begin
    addr_nxt        = addr_q;
    dout_nxt        = dout_q;
    doe_nxt         = 1'b0;
    ce_n_nxt        = 1'b1;
    oe_n_nxt        = 1'b1;
    we_n_nxt        = 1'b1;
    ub_n_nxt        = 1'b1;
    lb_n_nxt        = 1'b1;
    amiga_ack_nxt   = 1'b0;
    spi_ack_nxt     = spi_ack_q;
    amiga_rdata_nxt = amiga_rdata_q;
    spi_rdata_nxt   = spi_rdata_q;
    unique case (state_nxt)
      IDLE: ;
      SETUP: begin
        addr_nxt = sel_addr;
        if (!sel_read) dout_nxt = sel_wdata;
        ce_n_nxt = 1'b0;
        oe_n_nxt = !sel_read;
        doe_nxt  = !sel_read;
        ub_n_nxt = sel_ub_n;
        lb_n_nxt = sel_lb_n;
      end
      STROBE: begin
        ce_n_nxt = 1'b0;
        oe_n_nxt = !sel_read;
        we_n_nxt = sel_read;
        doe_nxt  = !sel_read;
        ub_n_nxt = sel_ub_n;
        lb_n_nxt = sel_lb_n;
      end
      DONE: begin
        // Address and write data stay driven for SRAM hold time
        ce_n_nxt = 1'b0;
        doe_nxt  = !sel_read;
        ub_n_nxt = sel_ub_n;
        lb_n_nxt = sel_lb_n;
        if (sel_spi) spi_ack_nxt   = sel_tag;
        else         amiga_ack_nxt = 1'b1;
        // Read data is captured on the edge leaving STROBE
        if (sel_read) begin
          if (sel_spi) spi_rdata_nxt   = bus.sram_data_in;
          else         amiga_rdata_nxt = bus.sram_data_in;
        end
      end
    endcase
  end

  always_ff @(posedge clk200 or negedge reset_n) begin
    if (!reset_n) begin
      addr_q        <= 20'd0;
      dout_q        <= 16'd0;
      doe_q         <= 1'b0;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      ub_n_q        <= 1'b1;
      lb_n_q        <= 1'b1;
      amiga_ack_q   <= 1'b0;
      spi_ack_q     <= 1'b0;
      amiga_rdata_q <= 16'd0;
      spi_rdata_q   <= 16'd0;
    end else begin
      addr_q        <= addr_nxt;
      dout_q        <= dout_nxt;
      doe_q         <= doe_nxt;
      ce_n_q        <= ce_n_nxt;
      oe_n_q        <= oe_n_nxt;
      we_n_q        <= we_n_nxt;
      ub_n_q        <= ub_n_nxt;
      lb_n_q        <= lb_n_nxt;
      amiga_ack_q   <= amiga_ack_nxt;
      spi_ack_q     <= spi_ack_nxt;
      amiga_rdata_q <= amiga_rdata_nxt;
      spi_rdata_q   <= spi_rdata_nxt;
    end
  end

  assign bus.sram_address    = addr_q;
  assign bus.sram_data_out   = dout_q;
  assign bus.sram_data_oe    = doe_q;
  assign bus.sram_ce_n       = ce_n_q;
  assign bus.sram_oe_n       = oe_n_q;
  assign bus.sram_we_n       = we_n_q;
  assign bus.sram_ub_n       = ub_n_q;
  assign bus.sram_lb_n       = lb_n_q;
  assign bus.amiga_ack       = amiga_ack_q;
  assign bus.spi_ack         = spi_ack_q;
  assign bus.amiga_rdata     = amiga_rdata_q;
  assign bus.spi_in_sram_out = spi_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// tb_sram_arbiter
// Directed bench for sram_arbiter with ACCESS_CYCLES=3. Each scenario drives
// its requests on a falling edge (that cycle is cycle 0) and the observe task
// samples cycles 1..N one time unit after each rising edge.
module tb_sram_arbiter;

  logic clk200 = 1'b0;
  logic reset_n;

  sram_arbiter_if bus ();

  sram_arbiter #(.ACCESS_CYCLES(3)) dut (
    .clk200  (clk200),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk200 = ~clk200;

  int n_chk  = 0;
  int n_pass = 0;

  int we_lo, oe_lo, a_ack_n, a_ack_first, s_ack_n, s_ack_first;
  int conflicts = 0;
  logic [19:0] snapa_addr, snapb_addr;
  logic [15:0] snapa_dout;
  logic        snapa_ub_n, snapa_lb_n, snapa_doe;
  logic        snapb_ub_n, snapb_lb_n, snapb_we_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic observe(input int ncyc, input int toggle_at);
    logic prev_sack;
    we_lo = 0; oe_lo = 0; a_ack_n = 0; a_ack_first = -1; s_ack_n = 0; s_ack_first = -1;
    prev_sack = bus.spi_ack;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk200); #1;
      if (!bus.sram_we_n) we_lo++;
      if (!bus.sram_oe_n) oe_lo++;
      if (bus.amiga_ack) begin
        a_ack_n++;
        if (a_ack_first < 0) a_ack_first = k;
      end
      if (bus.spi_ack != prev_sack) begin
        s_ack_n++;
        if (s_ack_first < 0) s_ack_first = k;
        prev_sack = bus.spi_ack;
      end
      if (!bus.sram_we_n && !bus.sram_oe_n) conflicts++;
      if (!bus.sram_oe_n && bus.sram_data_oe) conflicts++;
      if (k == 2) begin
        snapa_addr = bus.sram_address;
        snapa_dout = bus.sram_data_out;
        snapa_ub_n = bus.sram_ub_n;
        snapa_lb_n = bus.sram_lb_n;
        snapa_doe  = bus.sram_data_oe;
      end
      if (k == 8) begin
        snapb_addr = bus.sram_address;
        snapb_ub_n = bus.sram_ub_n;
        snapb_lb_n = bus.sram_lb_n;
        snapb_we_n = bus.sram_we_n;
      end
      if (k == toggle_at) bus.spi_req = ~bus.spi_req;
    end
  endtask

  task automatic amiga_cmd(input logic rd, input logic [19:0] a, input logic [15:0] d,
                           input logic ub, input logic lb);
    bus.amiga_read    = rd;
    bus.amiga_address = a;
    bus.amiga_wdata   = d;
    bus.amiga_ub      = ub;
    bus.amiga_lb      = lb;
    bus.amiga_req     = 1'b1;
  endtask

  task automatic spi_cmd(input logic rd, input logic [19:0] a, input logic [7:0] b, input logic ub);
    bus.spi_read_sram    = rd;
    bus.spi_address_sram = a;
    bus.spi_out_sram_in  = b;
    bus.spi_ub           = ub;
    bus.spi_req          = ~bus.spi_req;
  endtask

  task automatic amiga_drop();
    @(negedge clk200);
    bus.amiga_req = 1'b0;
    repeat (2) @(negedge clk200);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.amiga_req = 1'b0; bus.amiga_read = 1'b0; bus.amiga_address = '0;
    bus.amiga_ub = 1'b0; bus.amiga_lb = 1'b0; bus.amiga_wdata = '0;
    bus.spi_req = 1'b0; bus.spi_read_sram = 1'b0; bus.spi_address_sram = '0;
    bus.spi_ub = 1'b0; bus.spi_out_sram_in = '0; bus.sram_data_in = '0;

    // Reset state
    repeat (2) @(posedge clk200);
    #1;
    chk("rst_ctl", {24'd0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n,
                    bus.sram_lb_n, bus.sram_data_oe, bus.amiga_ack, bus.spi_ack}, 32'h0000_00F8);
    chk("rst_addr", {12'd0, bus.sram_address}, 32'h0);
    chk("rst_dout", {16'd0, bus.sram_data_out}, 32'h0);
    chk("rst_rdata", {bus.amiga_rdata, bus.spi_in_sram_out}, 32'h0);
    @(negedge clk200);
    reset_n = 1'b1;
    repeat (2) @(negedge clk200);

    // Amiga write, upper lane only
    amiga_cmd(1'b0, 20'h12345, 16'hBEEF, 1'b1, 1'b0);
    observe(8, 0);
    chk("aw_we_cycles", we_lo, 3);
    chk("aw_oe_cycles", oe_lo, 0);
    chk("aw_addr", {12'd0, snapa_addr}, 32'h12345);
    chk("aw_dout", {16'd0, snapa_dout}, 32'hBEEF);
    chk("aw_lanes", {30'd0, snapa_ub_n, snapa_lb_n}, 32'h1);
    chk("aw_doe", {31'd0, snapa_doe}, 32'h1);
    chk("aw_ack_cycle", a_ack_first, 5);
    chk("aw_ack_count", a_ack_n, 1);
    amiga_drop();

    // SPI read
    bus.sram_data_in = 16'hA55A;
    spi_cmd(1'b1, 20'h00010, 8'h00, 1'b0);
    observe(8, 0);
    chk("sr_oe_cycles", oe_lo, 4);
    chk("sr_we_cycles", we_lo, 0);
    chk("sr_addr", {12'd0, snapa_addr}, 32'h00010);
    chk("sr_doe", {31'd0, snapa_doe}, 32'h0);
    chk("sr_ack_cycle", s_ack_first, 5);
    chk("sr_ack_val", {31'd0, bus.spi_ack}, 32'h1);
    chk("sr_rdata", {16'd0, bus.spi_in_sram_out}, 32'hA55A);
    chk("sr_amiga_hold", {16'd0, bus.amiga_rdata}, 32'h0);
    repeat (2) @(negedge clk200);

    // SPI byte write, lower lane
    spi_cmd(1'b0, 20'h00ABC, 8'h3C, 1'b0);
    observe(8, 0);
    chk("sw_dout", {16'd0, snapa_dout}, 32'h3C3C);
    chk("sw_lanes", {30'd0, snapa_ub_n, snapa_lb_n}, 32'h2);
    chk("sw_we_cycles", we_lo, 3);
    chk("sw_ack_cycle", s_ack_first, 5);
    chk("sw_ack_val", {31'd0, bus.spi_ack}, 32'h0);
    chk("sw_rdata_hold", {16'd0, bus.spi_in_sram_out}, 32'hA55A);
    repeat (2) @(negedge clk200);

    // Tie with last grant SPI: Amiga first, SPI next
    bus.sram_data_in = 16'h0F0F;
    amiga_cmd(1'b0, 20'h00100, 16'h5555, 1'b1, 1'b1);
    spi_cmd(1'b1, 20'h00200, 8'h00, 1'b0);
    observe(14, 0);
    chk("tie1_first_addr", {12'd0, snapa_addr}, 32'h00100);
    chk("tie1_amiga_ack", a_ack_first, 5);
    chk("tie1_amiga_count", a_ack_n, 1);
    chk("tie1_spi_ack", s_ack_first, 11);
    chk("tie1_second_addr", {12'd0, snapb_addr}, 32'h00200);
    chk("tie1_spi_rdata", {16'd0, bus.spi_in_sram_out}, 32'h0F0F);
    amiga_drop();

    // Held Amiga request: served once, then again after a low sample
    bus.sram_data_in = 16'hC0DE;
    amiga_cmd(1'b1, 20'h00300, 16'h0000, 1'b0, 1'b0);
    observe(25, 0);
    chk("held_ack_count", a_ack_n, 1);
    chk("held_ack_cycle", a_ack_first, 5);
    chk("held_rdata", {16'd0, bus.amiga_rdata}, 32'hC0DE);
    chk("held_spi_hold", {16'd0, bus.spi_in_sram_out}, 32'h0F0F);
    @(negedge clk200);
    bus.amiga_req = 1'b0;
    @(negedge clk200);
    bus.sram_data_in = 16'hD00D;
    bus.amiga_req = 1'b1;
    observe(8, 0);
    chk("rearm_ack_cycle", a_ack_first, 5);
    chk("rearm_rdata", {16'd0, bus.amiga_rdata}, 32'hD00D);

    // Tie with last grant Amiga: SPI first; Amiga write with no lanes enabled
    @(negedge clk200);
    bus.amiga_req = 1'b0;
    @(negedge clk200);
    amiga_cmd(1'b0, 20'h00400, 16'h1111, 1'b0, 1'b0);
    spi_cmd(1'b0, 20'h00500, 8'h77, 1'b1);
    observe(14, 0);
    chk("tie2_first_addr", {12'd0, snapa_addr}, 32'h00500);
    chk("tie2_spi_dout", {16'd0, snapa_dout}, 32'h7777);
    chk("tie2_spi_lanes", {30'd0, snapa_ub_n, snapa_lb_n}, 32'h1);
    chk("tie2_spi_ack", s_ack_first, 5);
    chk("tie2_amiga_ack", a_ack_first, 11);
    chk("tie2_nolane", {29'd0, snapb_ub_n, snapb_lb_n, snapb_we_n}, 32'h6);
    chk("tie2_second_addr", {12'd0, snapb_addr}, 32'h00400);
    amiga_drop();

    // SPI toggle during an access stays pending and is served afterwards
    bus.sram_data_in = 16'h2222;
    spi_cmd(1'b1, 20'h00600, 8'h00, 1'b0);
    observe(14, 2);
    chk("tog_first_ack", s_ack_first, 5);
    chk("tog_ack_count", s_ack_n, 2);
    chk("tog_ack_val", {31'd0, bus.spi_ack}, 32'h0);
    chk("tog_rdata", {16'd0, bus.spi_in_sram_out}, 32'h2222);
    repeat (2) @(negedge clk200);

    // Reset in STROBE aborts without ack; the pending SPI write is redone once
    spi_cmd(1'b0, 20'h00700, 8'h99, 1'b1);
    repeat (3) begin
      @(posedge clk200); #1;
    end
    chk("mid_we_before", {31'd0, bus.sram_we_n}, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("mid_we_reset", {31'd0, bus.sram_we_n}, 32'h1);
    chk("mid_ack_reset", {30'd0, bus.amiga_ack, bus.spi_ack}, 32'h0);
    repeat (2) @(negedge clk200);
    reset_n = 1'b1;
    observe(14, 0);
    chk("mid_ack_count", s_ack_n, 1);
    chk("mid_ack_cycle", s_ack_first, 5);
    chk("mid_we_cycles", we_lo, 3);
    chk("mid_amiga_acks", a_ack_n, 0);
    chk("mid_addr", {12'd0, snapa_addr}, 32'h00700);

    chk("we_oe_exclusive", conflicts, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 3, giving the strobe length in clk200 cycles; legal range 1..15.
REQ-002 SHALL have clk200  in  1  sole clock; every flop is rising-edge clk200.
REQ-003 SHALL have reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have amiga_req  in  1  level request; held until amiga_ack.
REQ-005 SHALL have amiga_read  in  1  1=read, 0=write.
REQ-006 SHALL have amiga_address  in  20  word address.
REQ-007 SHALL have amiga_ub, amiga_lb  in  1 each  active-high byte enables for writes.
REQ-008 SHALL have amiga_wdata  in  16  write data.
REQ-009 SHALL have amiga_rdata  out  16  registered read data.
REQ-010 SHALL have amiga_ack  out  1  one-cycle completion pulse.
REQ-011 SHALL have spi_req  in  1  toggle request, already synchronised to clk200.
REQ-012 SHALL have spi_ack  out  1  toggle acknowledge.
REQ-013 SHALL have spi_read_sram  in  1  1=read, 0=write.
REQ-014 SHALL have spi_address_sram  in  20  word address.
REQ-015 SHALL have spi_ub  in  1  1=upper byte, 0=lower byte.
REQ-016 SHALL have spi_out_sram_in  in  8  SPI write byte.
REQ-017 SHALL have spi_in_sram_out  out  16  registered read word.
REQ-018 SHALL have sram_address  out  20  and sram_data_out  out  16  and sram_data_oe  out  1 (drive enable) and sram_data_in  in  16.
REQ-019 SHALL have sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM controls, all registered.

Function
REQ-020 SHALL treat SPI as pending when spi_req != spi_ack.
REQ-021 SHALL treat Amiga as pending when amiga_req=1 and the armed flag is set.
REQ-022 SHALL clear the armed flag on amiga_ack and set it again only after amiga_req is sampled 0, so that a held request is never served twice.
REQ-023 SHALL implement the states IDLE, SETUP, STROBE and DONE.
REQ-024 SHALL, in IDLE with one port pending, grant that port, latch its command, address, data and lane enables into internal registers, and go to SETUP.
REQ-025 SHALL, in IDLE with both ports pending, grant the port not granted last (round-robin); reset value of the last-grant flag is SPI, so Amiga wins the first tie.
REQ-026 SHALL, in SETUP (1 cycle): drive the latched address; ce_n=0; oe_n=0 for reads; for writes, data_oe=1 and lane enables set per REQ-030/REQ-031.
REQ-027 SHALL, in STROBE (ACCESS_CYCLES cycles, counted by a 4-bit counter): hold we_n=0 for writes; on the clock edge leaving STROBE, capture sram_data_in for reads.
REQ-028 SHALL, in DONE (1 cycle): return we_n and oe_n to 1 while keeping address and data driven for hold time; on Amiga grants pulse amiga_ack=1; on SPI grants set spi_ack to the spi_req value latched at grant; then go to IDLE.
REQ-029 SHALL give a latency from the IDLE grant cycle (cycle 0) to the ack-visible cycle of ACCESS_CYCLES+2, i.e. 5 with the default; back-to-back throughput is one access per ACCESS_CYCLES+3 cycles.
REQ-030 SHALL, on SPI writes, drive {byte,byte} on sram_data_out with only the lane selected by spi_ub enabled.
REQ-031 SHALL, on reads, enable both lanes; on Amiga writes, set ub_n=!amiga_ub and lb_n=!amiga_lb, and still complete and ack a write with both enables 0 with no lane strobed.
REQ-032 SHALL update amiga_rdata only on Amiga reads and spi_in_sram_out only on SPI reads; both hold their value otherwise.
REQ-033 SHALL leave an access in flight unaffected by a spi_req toggle during that access; a toggle after the grant stays pending and is served later.
REQ-034 SHALL never change any port's input registers outside the IDLE grant cycle.
REQ-035 SHALL never assert we_n=0 and oe_n=0 in the same cycle, and SHALL have data_oe=0 during reads.

Reset
REQ-036 SHALL, while reset_n=0, immediately force: state IDLE; ce_n, oe_n, we_n, ub_n and lb_n all 1; data_oe=0; amiga_ack=0; spi_ack=0; armed=1; last-grant=SPI; address, data_out, amiga_rdata and spi_in_sram_out all 0.
REQ-037 SHALL abort an access on reset mid-operation without an ack, and SHALL re-serve any request still pending after release.

Verification
REQ-038 SHALL cover an Amiga write: addr 0x12345, wdata 0xBEEF, ub=1, lb=0 -> we_n low for 3 cycles with ub_n=0, lb_n=1, data 0xBEEF, amiga_ack in cycle 5.
REQ-039 SHALL cover an SPI read: spi_req toggled 0->1, addr 0x00010, SRAM returns 0xA55A -> spi_in_sram_out=0xA55A and spi_ack=1 in cycle 5, oe_n low for 4 cycles.
REQ-040 SHALL cover a simultaneous request: Amiga and SPI pending in the same cycle after reset -> Amiga served first, then SPI; a repeat tie with both still pending -> SPI first.
REQ-041 SHALL cover a held Amiga request: amiga_req kept 1 for 20 cycles after ack -> exactly one access; drop to 0 then raise -> a second access occurs.
REQ-042 SHALL cover an SPI byte write: spi_ub=0, byte 0x3C -> data 0x3C3C, lb_n=0, ub_n=1.
REQ-043 SHALL cover reset mid-operation: reset_n pulsed low in STROBE -> we_n=1 immediately with no ack; after release the pending SPI request completes once.
